// File: rtl/xc_pkg.sv
// Shared definitions for the XC correlator packet format, used by both the
// transmitter and the receiver.
package xc_pkg;

  localparam int HEADER_SIZE = 64;
  localparam int FOOTER_SIZE = 64;

  localparam int TICK_OFS       = 0;
  localparam int TICK_W         = 16;
  localparam int FLAGS_OFS      = 16;
  localparam int FLAGS_W        = 4;
  localparam int LAG_CROSS_OFS  = 20;
  localparam int LAG_CROSS_W    = 8;
  localparam int LAG_AUTO_OFS   = 28;
  localparam int LAG_AUTO_W     = 8;
  localparam int DELAY_OFS      = 36;
  localparam int DELAY_W        = 12;
  localparam int NUM_INPUTS_OFS = 48;
  localparam int NUM_INPUTS_W   = 8;
  localparam int RESOLUTION_OFS = 56;
  localparam int RESOLUTION_W   = 8;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_CHAR   = 2'd1,
    ERR_LENGTH = 2'd2,
    ERR_HEADER = 2'd3
  } err_code_e;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  function automatic int payload_size(int num_inputs, int lag_cross, int lag_auto,
                                      int resolution, int has_xc);
    int corr;
    corr = has_xc * (num_inputs * (num_inputs - 1) / 2) * (2 * lag_cross - 1);
    return (corr * 2 + num_inputs * lag_auto * 2 + num_inputs) * resolution;
  endfunction

  function automatic int packet_size(int num_inputs, int lag_cross, int lag_auto,
                                     int resolution, int has_xc);
    return HEADER_SIZE + payload_size(num_inputs, lag_cross, lag_auto, resolution, has_xc)
           + FOOTER_SIZE;
  endfunction

endpackage

// File: rtl/hex_nibble_decode.sv
// ASCII byte classifier: hex digit value (either case), CR and LF detection.
module hex_nibble_decode
  import xc_pkg::*;
(
  input  logic [7:0] rx_byte,
  output logic       is_hex,
  output logic [3:0] nibble,
  output logic       is_cr,
  output logic       is_lf
);

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them to 10
      is_hex = 1'b1;
      nibble = rx_byte[3:0] + 4'd9;
    end
  end

  assign is_cr = (rx_byte == CHAR_CR);
  assign is_lf = (rx_byte == CHAR_LF);

endmodule

// File: rtl/xc_packet_rx.sv
// Receiver for the correlator ASCII-hex packet stream: reassembles one
// packet per CR-terminated line and decodes its header and footer.
//
// state | meaning
// IDLE  | waiting for the first hex char of a packet
// RECV  | shifting nibbles in, waiting for CR
// SKIP  | bad line, discarding until CR
module xc_packet_rx
  import xc_pkg::*;
#(
  parameter  int NUM_INPUTS          = 8,
  parameter  int LAG_CROSS           = 1,
  parameter  int LAG_AUTO            = 1,
  parameter  int RESOLUTION          = 24,
  parameter  int HAS_CROSSCORRELATOR = 1,
  parameter  int CHECK_HEADER        = 1,
  localparam int PACKET_SIZE  = packet_size(NUM_INPUTS, LAG_CROSS, LAG_AUTO, RESOLUTION,
                                            HAS_CROSSCORRELATOR),
  localparam int PAYLOAD_SIZE = PACKET_SIZE - HEADER_SIZE - FOOTER_SIZE
)(
  input  logic                    sysclk,
  input  logic                    reset,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_valid,
  output logic [PACKET_SIZE-1:0]  packet,
  output logic [PAYLOAD_SIZE-1:0] payload,
  output logic [63:0]             timestamp,
  output logic [TICK_W-1:0]       tick,
  output logic [FLAGS_W-1:0]      flags,
  output logic [LAG_CROSS_W-1:0]  lag_cross,
  output logic [LAG_AUTO_W-1:0]   lag_auto,
  output logic [DELAY_W-1:0]      delay_size,
  output logic [NUM_INPUTS_W-1:0] num_inputs,
  output logic [RESOLUTION_W-1:0] resolution,
  output logic                    packet_valid,
  output logic                    error,
  output logic [1:0]              error_code,
  output logic                    busy
);

  localparam int TOTAL_NIBBLES = PACKET_SIZE / 4;
  localparam int CNT_W         = $clog2(TOTAL_NIBBLES + 1);
  localparam int HDR_BASE      = PACKET_SIZE - HEADER_SIZE;
  localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL_NIBBLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_SKIP = 2'd2;

  if (PACKET_SIZE % 4 != 0) begin : g_bad_size
    $error("xc_packet_rx: PACKET_SIZE must be a whole number of nibbles");
  end

  logic [1:0]             state;
  logic [CNT_W-1:0]       count;
  logic [PACKET_SIZE-1:0] shift;
  logic                   is_hex, is_cr, is_lf;
  logic [3:0]             nibble;
  logic                   hdr_ok;

  hex_nibble_decode u_decode (
    .rx_byte (rx_byte),
    .is_hex  (is_hex),
    .nibble  (nibble),
    .is_cr   (is_cr),
    .is_lf   (is_lf)
  );

  assign hdr_ok = (CHECK_HEADER == 0) ||
                  ((shift[HDR_BASE+RESOLUTION_OFS +: RESOLUTION_W] == RESOLUTION_W'(RESOLUTION)) &&
                   (shift[HDR_BASE+NUM_INPUTS_OFS +: NUM_INPUTS_W] == NUM_INPUTS_W'(NUM_INPUTS - 1)));

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      shift        <= '0;
      packet       <= '0;
      packet_valid <= 1'b0;
      error        <= 1'b0;
      error_code   <= ERR_NONE;
    end else begin
      packet_valid <= 1'b0;
      error        <= 1'b0;
      // LF is transparent in every state
      if (rx_valid && !is_lf) begin
        case (state)
          ST_IDLE: begin
            if (is_hex) begin
              shift <= PACKET_SIZE'(nibble);
              count <= CNT_W'(1);
              state <= ST_RECV;
            end
          end
          ST_RECV: begin
            if (is_hex) begin
              if (count != TOTAL_CNT) begin
                shift <= {shift[PACKET_SIZE-5:0], nibble};
                count <= count + CNT_W'(1);
              end else begin
                error      <= 1'b1;
                error_code <= ERR_LENGTH;
                state      <= ST_SKIP;
              end
            end else if (is_cr) begin
              state <= ST_IDLE;
              if (count != TOTAL_CNT) begin
                error      <= 1'b1;
                error_code <= ERR_LENGTH;
              end else if (!hdr_ok) begin
                error      <= 1'b1;
                error_code <= ERR_HEADER;
              end else begin
                packet       <= shift;
                packet_valid <= 1'b1;
                error_code   <= ERR_NONE;
              end
            end else begin
              error      <= 1'b1;
              error_code <= ERR_CHAR;
              state      <= ST_SKIP;
            end
          end
          ST_SKIP: begin
            if (is_cr) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy       = (state == ST_RECV) || (state == ST_SKIP);
  assign payload    = packet[FOOTER_SIZE +: PAYLOAD_SIZE];
  assign timestamp  = packet[63:0];
  assign tick       = packet[HDR_BASE+TICK_OFS       +: TICK_W];
  assign flags      = packet[HDR_BASE+FLAGS_OFS      +: FLAGS_W];
  assign lag_cross  = packet[HDR_BASE+LAG_CROSS_OFS  +: LAG_CROSS_W];
  assign lag_auto   = packet[HDR_BASE+LAG_AUTO_OFS   +: LAG_AUTO_W];
  assign delay_size = packet[HDR_BASE+DELAY_OFS      +: DELAY_W];
  assign num_inputs = packet[HDR_BASE+NUM_INPUTS_OFS +: NUM_INPUTS_W];
  assign resolution = packet[HDR_BASE+RESOLUTION_OFS +: RESOLUTION_W];

endmodule

// File: tb/tb_xc_packet_rx.sv
// Scoreboard bench for xc_packet_rx at default parameters, plus a second
// instance with header checking disabled.
module tb_xc_packet_rx;
  import xc_pkg::*;

  localparam int PKT = 2048;
  localparam int PAY = 1920;
  localparam int NIB = 512;

  logic           sysclk = 1'b0;
  logic           reset = 1'b0;
  logic [7:0]     rx_byte = 8'h00;
  logic           rx_valid = 1'b0;

  logic [PKT-1:0] packet, nc_packet;
  logic [PAY-1:0] payload, nc_payload;
  logic [63:0]    timestamp, nc_timestamp;
  logic [15:0]    tick, nc_tick;
  logic [3:0]     flags, nc_flags;
  logic [7:0]     lag_cross, nc_lag_cross, lag_auto, nc_lag_auto;
  logic [11:0]    delay_size, nc_delay_size;
  logic [7:0]     num_inputs, nc_num_inputs, resolution, nc_resolution;
  logic           packet_valid, nc_packet_valid, error, nc_error, busy, nc_busy;
  logic [1:0]     error_code, nc_error_code;

  xc_packet_rx dut (
    .sysclk(sysclk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .packet(packet), .payload(payload), .timestamp(timestamp), .tick(tick),
    .flags(flags), .lag_cross(lag_cross), .lag_auto(lag_auto),
    .delay_size(delay_size), .num_inputs(num_inputs), .resolution(resolution),
    .packet_valid(packet_valid), .error(error), .error_code(error_code), .busy(busy)
  );

  xc_packet_rx #(.CHECK_HEADER(0)) dut_nc (
    .sysclk(sysclk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .packet(nc_packet), .payload(nc_payload), .timestamp(nc_timestamp), .tick(nc_tick),
    .flags(nc_flags), .lag_cross(nc_lag_cross), .lag_auto(nc_lag_auto),
    .delay_size(nc_delay_size), .num_inputs(nc_num_inputs), .resolution(nc_resolution),
    .packet_valid(nc_packet_valid), .error(nc_error), .error_code(nc_error_code),
    .busy(nc_busy)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc++;

  int nc_valid_cnt = 0;
  always @(negedge sysclk) if (nc_packet_valid === 1'b1) nc_valid_cnt++;

  typedef struct {
    bit             err;
    logic [1:0]     code;
    logic [PKT-1:0] pkt;
    int             cyc;
  } exp_t;

  exp_t           q[$];
  logic [PKT-1:0] last_pkt = '0;
  int             checks = 0;
  int             errors = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop one expectation per pulse; outputs must equal the last accepted packet.
  always @(negedge sysclk) begin
    exp_t e;
    if (packet_valid === 1'b1 || error === 1'b1) begin
      check("queue_nonempty", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pulse_kind", {62'd0, packet_valid, error}, {62'd0, !e.err, e.err});
        check("latency", 64'(cyc), 64'(e.cyc));
        check("error_code", 64'(error_code), 64'(e.code));
        if (!e.err) last_pkt = e.pkt;
        for (int i = 0; i < PKT/64; i++)
          check($sformatf("packet[%0d]", i), packet[i*64 +: 64], last_pkt[i*64 +: 64]);
        if (!e.err) begin
          check("resolution", 64'(resolution), 64'(e.pkt[PKT-1 -: 8]));
          check("num_inputs", 64'(num_inputs), 64'(e.pkt[PKT-9 -: 8]));
          check("delay_size", 64'(delay_size), 64'(e.pkt[PKT-17 -: 12]));
          check("lag_auto", 64'(lag_auto), 64'(e.pkt[PKT-29 -: 8]));
          check("lag_cross", 64'(lag_cross), 64'(e.pkt[PKT-37 -: 8]));
          check("flags", 64'(flags), 64'(e.pkt[PKT-45 -: 4]));
          check("tick", 64'(tick), 64'(e.pkt[PKT-49 -: 16]));
          check("timestamp", timestamp, e.pkt[63:0]);
          for (int i = 0; i < PAY/64; i++)
            check($sformatf("payload[%0d]", i), payload[i*64 +: 64], e.pkt[64+i*64 +: 64]);
        end
      end
    end
  end

  function automatic logic [PKT-1:0] make_pkt(logic [63:0] hdr, logic [63:0] ts);
    logic [PKT-1:0] p;
    p = '0;
    p[PKT-1 -: 64] = hdr;
    p[63:0] = ts;
    return p;
  endfunction

  function automatic logic [7:0] hex_char(logic [3:0] n, bit lower);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lower ? 8'h61 : 8'h41) + {4'h0, n - 4'd10};
  endfunction

  task automatic send_byte(logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge sysclk);
    rx_valid = 1'b0;
  endtask

  task automatic send_nibbles(logic [PKT-1:0] p, int first, int n, bit lower);
    logic [3:0] nb;
    for (int i = first; i < first + n; i++) begin
      nb = 4'h0;
      if (i < NIB) nb = p[PKT-1-4*i -: 4];
      send_byte(hex_char(nb, lower));
    end
  endtask

  task automatic expect_pulse(bit err, logic [1:0] code, logic [PKT-1:0] p);
    exp_t e;
    e.err  = err;
    e.code = code;
    e.pkt  = p;
    e.cyc  = cyc + 1;
    q.push_back(e);
  endtask

  task automatic send_packet(logic [PKT-1:0] p, bit lower);
    send_nibbles(p, 0, NIB, lower);
    expect_pulse(1'b0, ERR_NONE, p);
    send_byte(CHAR_CR);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge sysclk);
    check("drain_queue_size", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PKT-1:0] p1, p2, p3;
    int nc_before;
    p1 = make_pkt(64'h1807001000031388, 64'h00000000DEADBEEF);
    p2 = make_pkt(64'h180700100003ABCD, 64'h12345678CAFEF00D);
    p3 = make_pkt(64'h1F07001000031388, 64'h00000000DEADBEEF);

    // reset state
    repeat (3) @(negedge sysclk);
    check("rst_packet_hi", packet[PKT-1 -: 64], 64'd0);
    check("rst_timestamp", timestamp, 64'd0);
    check("rst_error_code", 64'(error_code), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pulses", {62'd0, packet_valid, error}, 64'd0);
    reset = 1'b1;
    @(negedge sysclk);

    // good uppercase packet
    send_nibbles(p1, 0, 1, 1'b0);
    check("busy_in_recv", 64'(busy), 64'd1);
    send_nibbles(p1, 1, NIB-1, 1'b0);
    expect_pulse(1'b0, ERR_NONE, p1);
    send_byte(CHAR_CR);
    check("busy_after_cr", 64'(busy), 64'd0);
    drain();
    check("p1_resolution", 64'(resolution), 64'h18);
    check("p1_num_inputs", 64'(num_inputs), 64'h07);
    check("p1_delay_size", 64'(delay_size), 64'h001);
    check("p1_lag_auto", 64'(lag_auto), 64'h00);
    check("p1_lag_cross", 64'(lag_cross), 64'h00);
    check("p1_flags", 64'(flags), 64'h3);
    check("p1_tick", 64'(tick), 64'h1388);
    check("p1_timestamp", timestamp, 64'hDEADBEEF);

    // lowercase, leading CRs, trailing LF
    send_byte(CHAR_CR);
    send_byte(CHAR_CR);
    send_packet(p1, 1'b1);
    send_byte(CHAR_LF);
    drain();
    check("lc_timestamp", timestamp, 64'hDEADBEEF);

    // short packet
    send_nibbles(p2, 0, NIB-1, 1'b0);
    expect_pulse(1'b1, ERR_LENGTH, p2);
    send_byte(CHAR_CR);
    drain();
    check("short_error_code", 64'(error_code), 64'd2);

    // long packet, then a good one
    send_nibbles(p2, 0, NIB, 1'b0);
    expect_pulse(1'b1, ERR_LENGTH, p2);
    send_byte(hex_char(4'h5, 1'b0));
    check("busy_in_skip", 64'(busy), 64'd1);
    send_byte(hex_char(4'h6, 1'b0));
    send_byte(CHAR_CR);
    check("long_error_code", 64'(error_code), 64'd2);
    send_packet(p2, 1'b0);
    drain();
    check("p2_tick", 64'(tick), 64'hABCD);

    // bad character at nibble 100; rest of line ignored
    send_nibbles(p1, 0, 100, 1'b0);
    expect_pulse(1'b1, ERR_CHAR, p1);
    send_byte(8'h47);
    send_nibbles(p1, 101, NIB-101, 1'b0);
    send_byte(8'h5A);
    send_byte(CHAR_CR);
    drain();
    check("badchar_error_code", 64'(error_code), 64'd1);
    check("badchar_busy", 64'(busy), 64'd0);
    send_packet(p1, 1'b0);
    drain();
    check("recover_error_code", 64'(error_code), 64'd0);

    // header mismatch: rejected with checking, accepted without
    nc_before = nc_valid_cnt;
    send_nibbles(p3, 0, NIB, 1'b0);
    expect_pulse(1'b1, ERR_HEADER, p3);
    send_byte(CHAR_CR);
    drain();
    check("hdr_error_code", 64'(error_code), 64'd3);
    check("hdr_resolution_kept", 64'(resolution), 64'h18);
    check("nc_valid_count", 64'(nc_valid_cnt), 64'(nc_before + 1));
    check("nc_resolution", 64'(nc_resolution), 64'h1F);
    check("nc_error_code", 64'(nc_error_code), 64'd0);

    // reset mid-packet: silent discard, outputs cleared
    send_nibbles(p1, 0, 300, 1'b0);
    reset = 1'b0;
    @(negedge sysclk);
    reset = 1'b1;
    last_pkt = '0;
    for (int i = 0; i < PKT/64; i++)
      check($sformatf("midrst_packet[%0d]", i), packet[i*64 +: 64], 64'd0);
    check("midrst_error_code", 64'(error_code), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_resolution", 64'(resolution), 64'd0);
    send_packet(p2, 1'b0);
    drain();
    check("final_tick", 64'(tick), 64'hABCD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
